// File: rtl/memory_stage.sv
// Memory pipeline stage: branch resolution, data-memory req/ack access with a
// timeout watchdog, stall generation and the ME/WB pipeline latch.
//
// state | meaning
// ------+-------------------------------------------------------------------
// IDLE  | no access outstanding; a new access is requested combinationally
// WAIT  | request held, waiting for ack; watchdog counting down
// HOLD  | access complete but ME/WB not loading; read data held in buffer
module memory_stage #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int PC_W        = 32,
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rf_we_i,
  input  logic              mem_we_i,
  input  logic              mem2rf_i,
  input  logic              branch_i,
  input  logic              check_eq_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic [ADDR_W-1:0] rf_waddr_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [PC_W-1:0]   pc_branch_i,
  input  logic              latch_en,
  input  logic              latch_clear,
  input  logic              dmem_ack_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [DATA_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  output logic              pc_src_o,
  output logic [PC_W-1:0]   pc_branch_o,
  output logic [DATA_W-1:0] rf_data_m_o,
  output logic [ADDR_W-1:0] rf_dst_m_o,
  output logic              rf_we_m_o,
  output logic              mem_stall_o,
  output logic              mem_err_o,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  // Down-counter loaded on entry to WAIT; reaching zero in WAIT is the
  // (TIMEOUT_CYC-1)-th waiting cycle, where the access is abandoned.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYC - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rbuf_q, rbuf_d;
  logic              err_q, err_d;
  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;

  logic              access;
  logic              done;
  logic [DATA_W-1:0] rdata_sel;

  assign access       = mem_we_i | mem2rf_i;
  assign pc_src_o     = branch_i & ((alu_result_i == '0) == check_eq_i);
  assign pc_branch_o  = pc_branch_i;
  assign dmem_addr_o  = alu_result_i;
  assign dmem_wdata_o = mem_wdata_i;
  assign rf_data_m_o  = alu_result_i;
  assign rf_dst_m_o   = rf_waddr_i;
  assign rf_we_m_o    = rf_we_i;
  assign mem_stall_o  = access & ~done;
  assign mem_err_o    = err_q;
  assign rf_we_o      = rf_we_q;
  assign rf_waddr_o   = rf_waddr_q;
  assign rf_wdata_o   = rf_wdata_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rbuf_d     = rbuf_q;
    err_d      = err_q;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    done       = 1'b0;
    rdata_sel  = dmem_rdata_i;
    case (state_q)
      S_IDLE: begin
        dmem_req_o = access;
        dmem_we_o  = mem_we_i;
        if (access) begin
          if (dmem_ack_i) begin
            done = 1'b1;
            if (!latch_en) begin
              state_d = S_HOLD;
              rbuf_d  = dmem_rdata_i;
            end
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = mem_we_i;
        if (dmem_ack_i) begin
          done = 1'b1;
        end else if (cnt_q == '0) begin
          // Abandoned access: writeback sees zero and the error is latched.
          done      = 1'b1;
          rdata_sel = '0;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
        if (done) begin
          state_d = latch_en ? S_IDLE : S_HOLD;
          rbuf_d  = rdata_sel;
          cnt_d   = '0;
        end
      end
      S_HOLD: begin
        done      = 1'b1;
        rdata_sel = rbuf_q;
        if (latch_en) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rbuf_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rbuf_q  <= rbuf_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || latch_clear) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else if (latch_en) begin
      if (mem_stall_o) begin
        rf_we_q    <= 1'b0;
        rf_waddr_q <= '0;
        rf_wdata_q <= '0;
      end else begin
        rf_we_q    <= rf_we_i;
        rf_waddr_q <= rf_waddr_i;
        rf_wdata_q <= mem2rf_i ? rdata_sel : alu_result_i;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage: inputs driven on the falling
// edge, combinational outputs checked mid-low-phase, registered ones after rise.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        rf_we_i, mem_we_i, mem2rf_i, branch_i, check_eq_i;
  logic [31:0] mem_wdata_i, alu_result_i, pc_branch_i, dmem_rdata_i;
  logic [4:0]  rf_waddr_i;
  logic        latch_en, latch_clear, dmem_ack_i;
  logic        dmem_req_o, dmem_we_o, pc_src_o, rf_we_m_o, mem_stall_o, mem_err_o, rf_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, pc_branch_o, rf_data_m_o, rf_wdata_o;
  logic [4:0]  rf_dst_m_o, rf_waddr_o;

  int total = 0;
  int bad = 0;
  int n_reqack = 0;
  int n_stall;

  memory_stage dut (
    .clk(clk), .reset(reset),
    .rf_we_i(rf_we_i), .mem_we_i(mem_we_i), .mem2rf_i(mem2rf_i),
    .branch_i(branch_i), .check_eq_i(check_eq_i),
    .mem_wdata_i(mem_wdata_i), .rf_waddr_i(rf_waddr_i),
    .alu_result_i(alu_result_i), .pc_branch_i(pc_branch_i),
    .latch_en(latch_en), .latch_clear(latch_clear),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .pc_src_o(pc_src_o), .pc_branch_o(pc_branch_o),
    .rf_data_m_o(rf_data_m_o), .rf_dst_m_o(rf_dst_m_o), .rf_we_m_o(rf_we_m_o),
    .mem_stall_o(mem_stall_o), .mem_err_o(mem_err_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (dmem_req_o && dmem_ack_i) n_reqack++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_instr();
    rf_we_i = 0; mem_we_i = 0; mem2rf_i = 0; branch_i = 0; check_eq_i = 0;
    mem_wdata_i = 0; rf_waddr_i = 0; alu_result_i = 0; pc_branch_i = 0;
    dmem_ack_i = 0; dmem_rdata_i = 0;
  endtask

  task automatic after_rise();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; latch_en = 0; latch_clear = 0;
    clear_instr();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rf_we", 32'(rf_we_o), 32'd0);
    chk("rst_waddr", 32'(rf_waddr_o), 32'd0);
    chk("rst_wdata", rf_wdata_o, 32'd0);
    chk("rst_err", 32'(mem_err_o), 32'd0);
    chk("rst_req", 32'(dmem_req_o), 32'd0);
    @(negedge clk);
    reset = 0;

    // ALU op, no memory access
    rf_we_i = 1; rf_waddr_i = 5; alu_result_i = 32'h1234; latch_en = 1;
    #1;
    chk("alu_req", 32'(dmem_req_o), 32'd0);
    chk("alu_stall", 32'(mem_stall_o), 32'd0);
    chk("alu_byp_data", rf_data_m_o, 32'h1234);
    chk("alu_byp_dst", 32'(rf_dst_m_o), 32'd5);
    chk("alu_byp_we", 32'(rf_we_m_o), 32'd1);
    after_rise();
    chk("alu_wb_we", 32'(rf_we_o), 32'd1);
    chk("alu_wb_waddr", 32'(rf_waddr_o), 32'd5);
    chk("alu_wb_wdata", rf_wdata_o, 32'h1234);

    // Zero-wait load
    @(negedge clk);
    rf_we_i = 1; rf_waddr_i = 7; mem2rf_i = 1; alu_result_i = 32'h40;
    dmem_ack_i = 1; dmem_rdata_i = 32'hDEADBEEF;
    #1;
    chk("zw_req", 32'(dmem_req_o), 32'd1);
    chk("zw_we", 32'(dmem_we_o), 32'd0);
    chk("zw_addr", dmem_addr_o, 32'h40);
    chk("zw_stall", 32'(mem_stall_o), 32'd0);
    after_rise();
    chk("zw_wb_wdata", rf_wdata_o, 32'hDEADBEEF);
    chk("zw_wb_waddr", 32'(rf_waddr_o), 32'd7);

    // Store acked on its third cycle
    @(negedge clk);
    clear_instr();
    mem_we_i = 1; mem_wdata_i = 32'hA5; alu_result_i = 32'h80; rf_waddr_i = 3;
    #1;
    chk("st_c1_req", 32'(dmem_req_o), 32'd1);
    chk("st_c1_we", 32'(dmem_we_o), 32'd1);
    chk("st_c1_wdata", dmem_wdata_o, 32'hA5);
    chk("st_c1_stall", 32'(mem_stall_o), 32'd1);
    after_rise();
    chk("st_bub1_wdata", rf_wdata_o, 32'd0);
    chk("st_bub1_waddr", 32'(rf_waddr_o), 32'd0);
    @(negedge clk);
    #1;
    chk("st_c2_req", 32'(dmem_req_o), 32'd1);
    chk("st_c2_stall", 32'(mem_stall_o), 32'd1);
    after_rise();
    chk("st_bub2_wdata", rf_wdata_o, 32'd0);
    @(negedge clk);
    dmem_ack_i = 1;
    #1;
    chk("st_c3_req", 32'(dmem_req_o), 32'd1);
    chk("st_c3_stall", 32'(mem_stall_o), 32'd0);
    after_rise();
    chk("st_wb_we", 32'(rf_we_o), 32'd0);
    chk("st_wb_waddr", 32'(rf_waddr_o), 32'd3);
    chk("st_wb_wdata", rf_wdata_o, 32'h80);
    @(negedge clk);
    clear_instr();
    #1;
    chk("st_req_drop", 32'(dmem_req_o), 32'd0);

    // Load that never gets acked
    @(negedge clk);
    rf_we_i = 1; mem2rf_i = 1; rf_waddr_i = 9; alu_result_i = 32'h100;
    dmem_rdata_i = 32'h55555555;
    n_stall = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!mem_stall_o) break;
      n_stall++;
      @(posedge clk);
      @(negedge clk);
    end
    chk("to_stall_cycles", 32'(n_stall), 32'd15);
    chk("to_req_last", 32'(dmem_req_o), 32'd1);
    chk("to_err_before", 32'(mem_err_o), 32'd0);
    after_rise();
    chk("to_err", 32'(mem_err_o), 32'd1);
    chk("to_wb_we", 32'(rf_we_o), 32'd1);
    chk("to_wb_waddr", 32'(rf_waddr_o), 32'd9);
    chk("to_wb_wdata", rf_wdata_o, 32'd0);

    // Next access after timeout
    @(negedge clk);
    rf_waddr_i = 10; alu_result_i = 32'h44; dmem_ack_i = 1; dmem_rdata_i = 32'h12345678;
    #1;
    chk("post_to_stall", 32'(mem_stall_o), 32'd0);
    after_rise();
    chk("post_to_wdata", rf_wdata_o, 32'h12345678);
    chk("post_to_err", 32'(mem_err_o), 32'd1);

    // Branch resolution
    @(negedge clk);
    clear_instr();
    latch_en = 0;
    branch_i = 1; check_eq_i = 1; alu_result_i = 0; pc_branch_i = 32'h1000;
    #1;
    chk("br_eq_taken", 32'(pc_src_o), 32'd1);
    chk("br_target", pc_branch_o, 32'h1000);
    @(negedge clk);
    alu_result_i = 7;
    #1;
    chk("br_eq_not", 32'(pc_src_o), 32'd0);
    @(negedge clk);
    check_eq_i = 0;
    #1;
    chk("br_ne_taken", 32'(pc_src_o), 32'd1);
    @(negedge clk);
    branch_i = 0;
    #1;
    chk("br_off", 32'(pc_src_o), 32'd0);

    // Load acked while ME/WB is frozen -> HOLD
    @(negedge clk);
    clear_instr();
    rf_we_i = 1; mem2rf_i = 1; rf_waddr_i = 12; alu_result_i = 32'h200;
    dmem_ack_i = 1; dmem_rdata_i = 32'hCAFEF00D;
    #1;
    chk("hold_req", 32'(dmem_req_o), 32'd1);
    chk("hold_stall0", 32'(mem_stall_o), 32'd0);
    after_rise();
    chk("hold_wb_frozen", rf_wdata_o, 32'h12345678);
    @(negedge clk);
    dmem_ack_i = 0; dmem_rdata_i = 32'hBAD0BAD0; latch_en = 1;
    #1;
    chk("hold_req_drop", 32'(dmem_req_o), 32'd0);
    chk("hold_stall1", 32'(mem_stall_o), 32'd0);
    after_rise();
    chk("hold_wb_wdata", rf_wdata_o, 32'hCAFEF00D);
    chk("hold_wb_waddr", 32'(rf_waddr_o), 32'd12);

    // latch_clear beats latch_en
    @(negedge clk);
    clear_instr();
    rf_we_i = 1; rf_waddr_i = 4; alu_result_i = 32'h77; latch_clear = 1;
    after_rise();
    chk("clr_we", 32'(rf_we_o), 32'd0);
    chk("clr_wdata", rf_wdata_o, 32'd0);
    @(negedge clk);
    latch_clear = 0;
    clear_instr();

    // Reset while waiting
    @(negedge clk);
    mem2rf_i = 1; rf_we_i = 1; rf_waddr_i = 2; alu_result_i = 32'h300;
    after_rise();
    @(negedge clk);
    #1;
    chk("rw_wait_req", 32'(dmem_req_o), 32'd1);
    chk("rw_wait_stall", 32'(mem_stall_o), 32'd1);
    chk("rw_err_sticky", 32'(mem_err_o), 32'd1);
    reset = 1;
    clear_instr();
    after_rise();
    @(negedge clk);
    #1;
    chk("rw_req", 32'(dmem_req_o), 32'd0);
    chk("rw_stall", 32'(mem_stall_o), 32'd0);
    chk("rw_err", 32'(mem_err_o), 32'd0);
    chk("rw_wb_we", 32'(rf_we_o), 32'd0);
    chk("rw_wb_wdata", rf_wdata_o, 32'd0);
    reset = 0;

    chk("reqack_count", 32'(n_reqack), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of execute; consumes the registered EX/ME control, ALU result, store data and branch target.
- Resolves branches and drives the fetch redirect.
- Performs data-memory loads/stores over a req/ack handshake, with a timeout watchdog.
- Stalls the pipeline while an access is outstanding; registers the ME/WB pipeline latch feeding writeback.

Parameters:
DATA_W, 32, register/memory data width
ADDR_W, 5, register-file address width
PC_W, 32, program-counter width
TIMEOUT_CYC, 16, maximum WAIT cycles before an access is abandoned (>=2)
CNT_W, 5, watchdog counter width (must hold TIMEOUT_CYC)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
rf_we_i  input  1  EX/ME: register write enable
mem_we_i  input  1  EX/ME: store
mem2rf_i  input  1  EX/ME: load (writeback data from memory)
branch_i  input  1  EX/ME: conditional branch
check_eq_i  input  1  EX/ME: 1 = branch on equal, 0 = branch on not-equal
mem_wdata_i  input  DATA_W  EX/ME: store data
rf_waddr_i  input  ADDR_W  EX/ME: destination register
alu_result_i  input  DATA_W  EX/ME: ALU result (memory address / writeback value / compare)
pc_branch_i  input  PC_W  EX/ME: branch target
latch_en  input  1  ME/WB latch load enable (from HU)
latch_clear  input  1  ME/WB latch clear (from HU)
dmem_ack_i  input  1  memory: access complete; rdata valid this cycle
dmem_rdata_i  input  DATA_W  memory: read data
dmem_req_o  output  1  memory: access request
dmem_we_o  output  1  memory: write strobe (valid with req)
dmem_addr_o  output  DATA_W  memory: address = alu_result_i
dmem_wdata_o  output  DATA_W  memory: write data = mem_wdata_i
pc_src_o  output  1  fetch: take branch
pc_branch_o  output  PC_W  fetch: branch target = pc_branch_i
rf_data_m_o  output  DATA_W  EX bypass: alu_result_i
rf_dst_m_o  output  ADDR_W  HU: rf_waddr_i
rf_we_m_o  output  1  HU: rf_we_i
mem_stall_o  output  1  HU: freeze upstream stages
mem_err_o  output  1  sticky: an access timed out
rf_we_o  output  1  ME/WB: register write enable
rf_waddr_o  output  ADDR_W  ME/WB: destination register
rf_wdata_o  output  DATA_W  ME/WB: writeback data

Behaviour:
- access = mem_we_i | mem2rf_i. Branch resolution is combinational: pc_src_o = branch_i & ((alu_result_i == 0) == check_eq_i).
- Pass-throughs (dmem_addr/wdata, pc_branch_o, rf_data_m_o, rf_dst_m_o, rf_we_m_o) are combinational.
- FSM states and transitions:
  - IDLE:
    - dmem_req_o = access; dmem_we_o = mem_we_i.
    - access & ack -> done. If latch_en, stay IDLE; else go to HOLD and capture rdata.
    - access & ~ack -> WAIT, cnt <= 1.
  - WAIT:
    - dmem_req_o = 1; dmem_we_o = mem_we_i.
    - ack -> done, then IDLE (latch_en=1) or HOLD (latch_en=0).
    - ~ack & cnt == TIMEOUT_CYC-1 -> timeout: done with rdata forced to 0 and mem_err_o <= 1, then IDLE or HOLD as above.
    - Otherwise cnt++.
  - HOLD:
    - dmem_req_o = 0; uses the buffered rdata; done = 1.
    - latch_en -> IDLE.
- Stall rule: mem_stall_o = access & ~done. Latency is 0 extra cycles if ack arrives in the request cycle; otherwise 1 stall cycle per cycle without ack.
- Memory-protocol invariant: exactly one request completes per instruction. req never reasserts for the same instruction after its ack.
- ME/WB latch (registered):
  - reset or latch_clear: all outputs 0.
  - Else if latch_en:
    - mem_stall_o = 1: load a bubble (all outputs 0).
    - Otherwise: rf_we_o <= rf_we_i; rf_waddr_o <= rf_waddr_i; rf_wdata_o <= mem2rf_i ? (ack ? dmem_rdata_i : buffered/forced rdata) : alu_result_i.
  - Else: hold.
  - latch_clear has priority over latch_en.
- Reset: state IDLE, cnt 0, buffer 0, mem_err_o 0, all ME/WB outputs 0. Reset mid-WAIT abandons the access; req drops the next cycle.
- mem_err_o clears only on reset.

Test Plan:
- ALU op: rf_we=1, waddr=5, alu_result=0x1234, no access, latch_en=1 -> next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0x1234; dmem_req_o=0; mem_stall_o=0 throughout.
- Zero-wait load: mem2rf=1, alu_result=0x40, ack=1 with rdata=0xDEADBEEF in the same cycle -> req=1, we=0, addr=0x40, no stall; next cycle rf_wdata_o=0xDEADBEEF.
- 3-cycle store: mem_we=1, wdata=0xA5, ack arrives on the 3rd cycle -> mem_stall_o=1 for 2 cycles; WB receives 2 bubbles, then the store entry with rf_we_o=0; exactly one ack-terminated request.
- Timeout: load with ack held at 0 -> stall for TIMEOUT_CYC-1=15 cycles; mem_err_o rises; rf_wdata_o=0 is written; next access still works and mem_err_o stays 1.
- Branch: branch=1, check_eq=1, alu_result=0 -> pc_src_o=1, pc_branch_o=pc_branch_i. Same with alu_result=7 -> pc_src_o=0. With check_eq=0 and alu_result=7 -> pc_src_o=1.
- HOLD and reset:
  - Load acked while latch_en=0 -> req drops the next cycle (HOLD). When latch_en rises, rf_wdata_o=rdata.
  - reset asserted in WAIT -> next cycle req=0, stall=0, all outputs 0.
